fft_spectrum_peak: RTL



---
 rtl/fft_spectrum_peak.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_spectrum_peak.sv
// rtl/fft_spectrum_peak.sv - FFT magnitude estimator with per-bin exponential averaging and peak search
// Four-stage pipeline: abs, magnitude + RAM read, RAM data, average/write/output.
module fft_spectrum_peak #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int PEAK_LO = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [2:0]              avg_shift,
  output logic [WIDTH-1:0]        mag_data,
  output logic [IDX_W-1:0]        mag_idx,
  output logic                    mag_valid,
  output logic                    mag_sop,
  output logic                    mag_eop,
  output logic                    peak_valid,
  output logic [IDX_W-1:0]        peak_idx,
  output logic [WIDTH-1:0]        peak_mag,
  output logic                    frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0] PEAK_LO_I = IDX_W'(PEAK_LO);
  localparam logic [IDX_W-1:0] PEAK_HI_I = IDX_W'(FFT_LEN / 2 - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic             seed;
    logic [2:0]       k;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [WIDTH-1:0] abs_u(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] ux;
    ux = x;
    return x[WIDTH-1] ? (~ux + 1'b1) : ux;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, beat_idx;
  logic             seed_q, seed_d, fseed_q, fseed_d;
  logic [2:0]       k_q, k_d, fk_q, fk_d;
  logic             active, beat_bad, fwd, err_d;

  // Frame checker: offending beats are dropped, so a broken frame never reaches mag_eop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seed_d   = seed_q;
    fseed_d  = fseed_q;
    k_d      = k_q;
    fk_d     = fk_q;
    err_d    = 1'b0;
    fwd      = 1'b0;
    beat_idx = in_sop ? '0 : cnt_q + 1'b1;
    active   = in_sop || (state_q == RUN);
    beat_bad = active && (in_eop != (beat_idx == LAST_IDX));
    if (in_valid) begin
      if ((in_sop && state_q == RUN) || beat_bad) err_d = 1'b1;
      if (beat_bad) begin
        state_d = IDLE;
        seed_d  = 1'b1;
      end else if (active) begin
        fwd   = 1'b1;
        cnt_d = beat_idx;
        if (in_sop) begin
          fseed_d = seed_q || (avg_shift != k_q);
          fk_d    = avg_shift;
          k_d     = avg_shift;
        end
        if (in_eop) begin
          state_d = IDLE;
          seed_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seed_q    <= 1'b1;
      fseed_q   <= 1'b1;
      k_q       <= '0;
      fk_q      <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      fseed_q   <= fseed_d;
      k_q       <= k_d;
      fk_q      <= fk_d;
      frame_err <= err_d;
    end
  end

  logic             v1_q, v2_q, v3_q;
  tag_t             tag1_q, tag2_q, tag3_q;
  logic [WIDTH-1:0] a1_q, b1_q, mag2_q, mag3_q, rd_q;
  logic [WIDTH-1:0] mx, mn, mag_c;
  logic [WIDTH-1:0] ram [FFT_LEN];

  always_comb begin
    mx    = (a1_q > b1_q) ? a1_q : b1_q;
    mn    = (a1_q > b1_q) ? b1_q : a1_q;
    mag_c = mx + (mn >> 2) + (mn >> 3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      a1_q   <= '0;
      b1_q   <= '0;
      mag2_q <= '0;
      mag3_q <= '0;
    end else begin
      v1_q   <= fwd;
      tag1_q <= '{sop: in_sop, eop: in_eop, seed: fseed_d, k: fk_d, idx: beat_idx};
      a1_q   <= abs_u(in_re);
      b1_q   <= abs_u(in_im);
      v2_q   <= v1_q;
      tag2_q <= tag1_q;
      mag2_q <= mag_c;
      v3_q   <= v2_q;
      tag3_q <= tag2_q;
      mag3_q <= mag2_q;
    end
  end

  logic signed [WIDTH:0] mag_s, old_s, diff, step;
  logic [WIDTH-1:0]      avg_c;

  // The true average always lies between old and mag, so WIDTH-bit wrap-around is exact.
  always_comb begin
    mag_s = {1'b0, mag3_q};
    old_s = {1'b0, rd_q};
    diff  = mag_s - old_s;
    step  = diff >>> tag3_q.k;
    avg_c = tag3_q.seed ? mag3_q : (rd_q + step[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (v3_q) ram[tag3_q.idx] <= avg_c;
    if (v2_q) rd_q <= ram[tag2_q.idx];
  end

  logic [WIDTH-1:0] best_mag_q, best_mag_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  always_comb begin
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    if (v3_q) begin
      if (tag3_q.sop) begin
        best_mag_d = '0;
        best_idx_d = PEAK_LO_I;
      end
      if (tag3_q.idx >= PEAK_LO_I && tag3_q.idx <= PEAK_HI_I && avg_c > best_mag_d) begin
        best_mag_d = avg_c;
        best_idx_d = tag3_q.idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_valid  <= 1'b0;
      mag_sop    <= 1'b0;
      mag_eop    <= 1'b0;
      mag_data   <= '0;
      mag_idx    <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
    end else begin
      mag_valid  <= v3_q;
      mag_sop    <= v3_q && tag3_q.sop;
      mag_eop    <= v3_q && tag3_q.eop;
      if (v3_q) begin
        mag_data <= avg_c;
        mag_idx  <= tag3_q.idx;
      end
      best_mag_q <= best_mag_d;
      best_idx_q <= best_idx_d;
      peak_valid <= mag_valid && mag_eop;
      if (mag_valid && mag_eop) begin
        peak_idx <= best_idx_q;
        peak_mag <= best_mag_q;
      end
    end
  end

endmodule
